range_serializer: RTL and testbench

RANGE_SERIALIZER -- requirements
Module: range_serializer

---
 rtl/range_serializer.sv | 144 ++++++++++++++
 tb/tb_range_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_serializer.sv
// Captures {error_in, range_in} on each rising edge of finish into a small FIFO and
// shifts entries out MSB first as START/DATA/STOP frames. Optional parity: RANGE_SERIALIZER_PARITY_EN.
module range_serializer #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       range_in,
  input  logic                   error_in,
  input  logic                   finish,
  input  logic                   ser_en,
  output logic                   ser_out,
  output logic                   frame_out,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH + 1);
  localparam int EW = WIDTH + 1;

`ifdef RANGE_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_reg;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            finish_prev_reg;
  logic            overflow_reg;
  logic            ser_out_reg;
  logic            frame_out_reg;
  logic [EW-1:0]   shift_reg;
  logic [IW-1:0]   bit_idx_reg;
`ifdef RANGE_SERIALIZER_PARITY_EN
  logic            parity_reg;
`endif

  logic capture;
  logic full;
  logic pop;
  logic push;

  assign capture = finish & ~finish_prev_reg;
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign pop     = (state_reg == IDLE) && ser_en && (count_reg != '0);
  // A full FIFO still accepts a capture when the same edge frees a slot.
  assign push    = capture && (!full || pop);

  assign ser_out    = ser_out_reg;
  assign frame_out  = frame_out_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_reg] <= {error_in, range_in};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      finish_prev_reg <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      finish_prev_reg <= finish;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
      if (capture && full && !pop) overflow_reg <= 1'b1;
    end
  end

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_idx_reg   <= '0;
      ser_out_reg   <= 1'b0;
      frame_out_reg <= 1'b0;
`ifdef RANGE_SERIALIZER_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else if (ser_en) begin
      case (state_reg)
        IDLE: begin
          if (pop) begin
            shift_reg     <= mem[rd_ptr_reg];
`ifdef RANGE_SERIALIZER_PARITY_EN
            parity_reg    <= ^mem[rd_ptr_reg];
`endif
            state_reg     <= START;
            ser_out_reg   <= 1'b1;
            frame_out_reg <= 1'b1;
          end
        end
        START: begin
          state_reg   <= DATA;
          bit_idx_reg <= '0;
          ser_out_reg <= shift_reg[EW-1];
          shift_reg   <= shift_reg << 1;
        end
        DATA: begin
          if (bit_idx_reg == IW'(WIDTH)) begin
`ifdef RANGE_SERIALIZER_PARITY_EN
            state_reg     <= PAR;
            ser_out_reg   <= parity_reg;
`else
            state_reg     <= STOP;
            ser_out_reg   <= 1'b0;
            frame_out_reg <= 1'b0;
`endif
          end else begin
            bit_idx_reg <= bit_idx_reg + 1'b1;
            ser_out_reg <= shift_reg[EW-1];
            shift_reg   <= shift_reg << 1;
          end
        end
`ifdef RANGE_SERIALIZER_PARITY_EN
        PAR: begin
          state_reg     <= STOP;
          ser_out_reg   <= 1'b0;
          frame_out_reg <= 1'b0;
        end
`endif
        STOP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg     <= IDLE;
          ser_out_reg   <= 1'b0;
          frame_out_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_range_serializer.sv
// Directed bench for range_serializer: latency, finish-hold, overflow, ser_en stalls,
// mid-frame reset and full-FIFO push/pop collision. Handles RANGE_SERIALIZER_PARITY_EN builds.
module tb_range_serializer;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  range_in = '0;
  logic        error_in = 1'b0;
  logic        finish = 1'b0;
  logic        ser_en = 1'b0;
  logic        ser_out;
  logic        frame_out;
  logic [2:0]  fifo_count;
  logic        overflow;

  int total = 0;
  int bad = 0;

  logic [31:0] fq_bits[$];
  int          fq_len[$];
  logic [31:0] cur_bits = '0;
  int          cur_len = 0;

`ifdef RANGE_SERIALIZER_PARITY_EN
  localparam int FLEN = 14;
  localparam logic [31:0] F_2A5 = 32'h2A96;
  localparam logic [31:0] F_001 = 32'h2006;
`else
  localparam int FLEN = 13;
  localparam logic [31:0] F_2A5 = 32'h154A;
  localparam logic [31:0] F_001 = 32'h1002;
`endif

  range_serializer #(.WIDTH(10), .DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .range_in   (range_in),
    .error_in   (error_in),
    .finish     (finish),
    .ser_en     (ser_en),
    .ser_out    (ser_out),
    .frame_out  (frame_out),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  // Frame word: start bit, entry MSB first, optional even parity, stop bit.
  function automatic logic [31:0] frm(input logic [10:0] e);
`ifdef RANGE_SERIALIZER_PARITY_EN
    return {18'd0, 1'b1, e, ^e, 1'b0};
`else
    return {19'd0, 1'b1, e, 1'b0};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    finish = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    fq_bits.delete();
    fq_len.delete();
  endtask

  task automatic pulse(input logic [9:0] r, input logic e);
    range_in = r;
    error_in = e;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    tick();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (fq_bits.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("frame_count", fq_bits.size(), n);
  endtask

  task automatic check_frame(input string tag, input int i, input logic [31:0] exp);
    logic [31:0] b;
    logic [31:0] l;
    b = (i < fq_bits.size()) ? fq_bits[i] : 32'hFFFF_FFFF;
    l = (i < fq_len.size()) ? fq_len[i] : 32'hFFFF_FFFF;
    check(tag, b, exp);
    check({tag, "_len"}, l, FLEN);
  endtask

  // One symbol per cycle in which the DUT is allowed to advance.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        cur_bits = '0;
        cur_len = 0;
      end else if (ser_en) begin
        if (frame_out) begin
          cur_bits = {cur_bits[30:0], ser_out};
          cur_len++;
        end else if (cur_len != 0) begin
          cur_bits = {cur_bits[30:0], ser_out};
          cur_len++;
          fq_bits.push_back(cur_bits);
          fq_len.push_back(cur_len);
          $display("frame bits=%h len=%0d", cur_bits, cur_len);
          cur_bits = '0;
          cur_len = 0;
        end
      end
    end
  end

  initial begin
    logic v;
    int pk;
    int fo;
    int c;

    #1;
    check("rst_ser_out", ser_out, 0);
    check("rst_frame_out", frame_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset_dut();

    // Basic frame and latency
    ser_en = 1'b1;
    range_in = 10'h2A5;
    error_in = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    @(negedge clock);
    check("lat_n1_count", fifo_count, 1);
    check("lat_n1_frame", frame_out, 0);
    @(negedge clock);
    check("lat_n2_start", ser_out, 1);
    check("lat_n2_frame", frame_out, 1);
    check("lat_n2_count", fifo_count, 0);
    @(negedge clock);
    check("lat_n3_bit10", ser_out, 0);
    @(posedge clock);
    #1;
    wait_frames(1, 100);
    check_frame("f2a5", 0, F_2A5);

    // finish held high for five cycles
    reset_dut();
    ser_en = 1'b1;
    range_in = 10'h001;
    error_in = 1'b0;
    pk = 0;
    finish = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) finish = 1'b0;
      @(negedge clock);
      if (int'(fifo_count) > pk) pk = int'(fifo_count);
      @(posedge clock);
      #1;
    end
    check("hold_peak", pk, 1);
    repeat (30) tick();
    check("hold_frames", fq_bits.size(), 1);
    check_frame("f001", 0, F_001);

    // Overflow with downstream stalled
    reset_dut();
    ser_en = 1'b0;
    pulse(10'h111, 1'b0);
    pulse(10'h222, 1'b1);
    pulse(10'h333, 1'b0);
    pulse(10'h044, 1'b1);
    pulse(10'h155, 1'b0);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    ser_en = 1'b1;
    wait_frames(4, 300);
    repeat (40) tick();
    check("ovf_frames", fq_bits.size(), 4);
    check_frame("ovf_f0", 0, frm(11'h111));
    check_frame("ovf_f1", 1, frm(11'h622));
    check_frame("ovf_f2", 2, frm(11'h333));
    check_frame("ovf_f3", 3, frm(11'h444));
    check("ovf_sticky", overflow, 1);

    // ser_en toggling during DATA
    reset_dut();
    ser_en = 1'b1;
    pulse(10'h3FF, 1'b1);
    c = 0;
    while (!frame_out && c < 20) begin
      tick();
      c++;
    end
    check("tog_started", frame_out, 1);
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      ser_en = 1'b0;
      @(negedge clock);
      v = ser_out;
      @(posedge clock);
      #1;
      ser_en = 1'b1;
      @(negedge clock);
      check("tog_hold", ser_out, v);
      check("tog_frame", frame_out, 1);
      @(posedge clock);
      #1;
    end
    wait_frames(1, 100);
    check_frame("tog_f", 0, frm(11'h7FF));

    // Reset in the middle of DATA
    reset_dut();
    ser_en = 1'b0;
    for (int k = 0; k < 5; k++) pulse(10'h3FF, 1'b1);
    ser_en = 1'b1;
    c = 0;
    while (!frame_out && c < 20) begin
      tick();
      c++;
    end
    repeat (3) tick();
    check("mid_frame_pre", frame_out, 1);
    check("mid_ser_pre", ser_out, 1);
    check("mid_ovf_pre", overflow, 1);
    reset = 1'b0;
    #1;
    check("mid_ser_out", ser_out, 0);
    check("mid_frame_out", frame_out, 0);
    check("mid_count", fifo_count, 0);
    check("mid_overflow", overflow, 0);
    repeat (2) tick();
    reset = 1'b1;
    fq_bits.delete();
    fq_len.delete();
    fo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (frame_out) fo = 1;
      @(posedge clock);
      #1;
    end
    check("mid_no_resume", fo, 0);
    check("mid_no_frames", fq_bits.size(), 0);

    // Full FIFO, capture coincides with a pop
    reset_dut();
    ser_en = 1'b0;
    pulse(10'h0AA, 1'b0);
    pulse(10'h155, 1'b1);
    pulse(10'h3C3, 1'b0);
    pulse(10'h00F, 1'b1);
    check("col_full", fifo_count, 4);
    range_in = 10'h2F0;
    error_in = 1'b0;
    finish = 1'b1;
    ser_en = 1'b1;
    tick();
    finish = 1'b0;
    @(negedge clock);
    check("col_count", fifo_count, 4);
    check("col_overflow", overflow, 0);
    @(posedge clock);
    #1;
    wait_frames(5, 400);
    check_frame("col_f0", 0, frm(11'h0AA));
    check_frame("col_f1", 1, frm(11'h555));
    check_frame("col_f2", 2, frm(11'h3C3));
    check_frame("col_f3", 3, frm(11'h40F));
    check_frame("col_f4", 4, frm(11'h2F0));
    check("col_empty", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
